multi_channel_timer: RTL and testbench

MULTI_CHANNEL_TIMER -- requirements
Module: multi_channel_timer

---
 rtl/timer_pkg.sv | 14 +
 rtl/timer_channel.sv | 72 +++++++
 rtl/multi_channel_timer.sv | 132 +++++++++++++
 tb/tb_multi_channel_timer.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
// rtl/timer_pkg.sv - shared state encoding and default sizes for the multi-channel timer
package timer_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_N_CH  = 4;
    localparam int DEF_PRE_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } timer_state_e;

endpackage

// File: rtl/timer_channel.sv
// rtl/timer_channel.sv - one capture/overrun/alarm channel of the multi-channel timer
module timer_channel
    import timer_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             armed_in,
    input  logic             capture_in,
    input  logic             rst_capture_in,
    input  logic             alarm_en_in,
    input  logic [WIDTH-1:0] alarm_val_in,
    input  logic [WIDTH-1:0] counter_in,
    input  logic             tick_upd_in,
    output logic [WIDTH-1:0] captured_out,
    output logic             valid_out,
    output logic             ovr_out,
    output logic             alarm_out
);

    logic             cap_prev_q, rcap_prev_q;
    logic [WIDTH-1:0] captured_q, captured_d;
    logic             valid_q, valid_d;
    logic             ovr_q, ovr_d;
    logic             alarm_q, alarm_d;
    logic             cap_ev, rcap_ev;

    // Edge events and next capture/flag/alarm state; capture beats a simultaneous flag clear.
    always_comb begin
        cap_ev     = armed_in & capture_in & ~cap_prev_q;
        rcap_ev    = armed_in & rst_capture_in & ~rcap_prev_q;
        captured_d = captured_q;
        valid_d    = valid_q;
        ovr_d      = ovr_q;
        if (cap_ev) begin
            captured_d = counter_in;
            valid_d    = 1'b1;
            ovr_d      = rcap_ev ? 1'b0 : (ovr_q | valid_q);
        end else if (rcap_ev) begin
            valid_d = 1'b0;
            ovr_d   = 1'b0;
        end
        // The counter already shows the new value; pulse only if a tick put it there.
        alarm_d = tick_upd_in & alarm_en_in & (counter_in == alarm_val_in);
    end

    // Channel registers with asynchronous clear.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            cap_prev_q  <= 1'b0;
            rcap_prev_q <= 1'b0;
            captured_q  <= '0;
            valid_q     <= 1'b0;
            ovr_q       <= 1'b0;
            alarm_q     <= 1'b0;
        end else begin
            cap_prev_q  <= capture_in;
            rcap_prev_q <= rst_capture_in;
            captured_q  <= captured_d;
            valid_q     <= valid_d;
            ovr_q       <= ovr_d;
            alarm_q     <= alarm_d;
        end
    end

    assign captured_out = captured_q;
    assign valid_out    = valid_q;
    assign ovr_out      = ovr_q;
    assign alarm_out    = alarm_q;

endmodule

// File: rtl/multi_channel_timer.sv
// rtl/multi_channel_timer.sv - prescaled run/pause/oneshot timer with per-channel capture and alarms
module multi_channel_timer
    import timer_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int N_CH  = DEF_N_CH,
    parameter int PRE_W = DEF_PRE_W
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  start_in,
    input  logic                  stop_in,
    input  logic                  clear_in,
    input  logic                  oneshot_in,
    input  logic [PRE_W-1:0]      prescale_in,
    input  logic [WIDTH-1:0]      reload_in,
    input  logic [N_CH-1:0]       capture_in,
    input  logic [N_CH-1:0]       rst_capture_in,
    input  logic [N_CH-1:0]       alarm_en_in,
    input  logic [N_CH*WIDTH-1:0] alarm_in,
    output logic [WIDTH-1:0]      counter_out,
    output logic [N_CH*WIDTH-1:0] captured_out,
    output logic [N_CH-1:0]       capture_valid_out,
    output logic [N_CH-1:0]       capture_ovr_out,
    output logic [N_CH-1:0]       alarm_out,
    output logic                  wrap_out,
    output logic                  running_out
);

    timer_state_e     state_q, state_d;
    logic [WIDTH-1:0] counter_q, counter_d;
    logic [PRE_W-1:0] pre_q, pre_d;
    logic             wrap_q, wrap_d;
    logic             upd_q, upd_d;
    // Suppresses edge events on the first clock after reset so held-high inputs are ignored.
    logic             armed_q;
    logic             start_prev_q, stop_prev_q, clear_prev_q;
    logic             start_ev, stop_ev, clear_ev;
    logic             tick, tick_eff, term;

    // Next-state, prescaler and counter logic; stop beats start, clear beats a tick.
    always_comb begin
        start_ev  = armed_q & start_in & ~start_prev_q;
        stop_ev   = armed_q & stop_in & ~stop_prev_q;
        clear_ev  = armed_q & clear_in & ~clear_prev_q;
        tick      = (state_q == ST_RUN) && (pre_q == prescale_in);
        tick_eff  = tick & ~clear_ev;
        term      = (counter_q == reload_in);
        state_d   = state_q;
        counter_d = counter_q;
        pre_d     = pre_q;
        wrap_d    = 1'b0;
        upd_d     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_ev && !stop_ev) state_d = ST_RUN;
            end
            ST_RUN: begin
                pre_d = tick ? '0 : pre_q + PRE_W'(1);
                if (tick_eff) begin
                    wrap_d = term;
                    if (!(term && oneshot_in)) begin
                        counter_d = term ? '0 : counter_q + WIDTH'(1);
                        upd_d     = 1'b1;
                    end
                end
                if (stop_ev) state_d = ST_IDLE;
                else if (tick_eff && term && oneshot_in) state_d = ST_DONE;
            end
            ST_DONE: begin
                if (start_ev && !stop_ev) begin
                    state_d   = ST_RUN;
                    counter_d = '0;
                    pre_d     = '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (clear_ev) begin
            counter_d = '0;
            pre_d     = '0;
        end
    end

    // Timer state registers with asynchronous clear.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q      <= ST_IDLE;
            counter_q    <= '0;
            pre_q        <= '0;
            wrap_q       <= 1'b0;
            upd_q        <= 1'b0;
            armed_q      <= 1'b0;
            start_prev_q <= 1'b0;
            stop_prev_q  <= 1'b0;
            clear_prev_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            counter_q    <= counter_d;
            pre_q        <= pre_d;
            wrap_q       <= wrap_d;
            upd_q        <= upd_d;
            armed_q      <= 1'b1;
            start_prev_q <= start_in;
            stop_prev_q  <= stop_in;
            clear_prev_q <= clear_in;
        end
    end

    assign counter_out = counter_q;
    assign wrap_out    = wrap_q;
    assign running_out = (state_q == ST_RUN);

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        timer_channel #(.WIDTH(WIDTH)) u_ch (
            .clk_in        (clk_in),
            .rst_in        (rst_in),
            .armed_in      (armed_q),
            .capture_in    (capture_in[i]),
            .rst_capture_in(rst_capture_in[i]),
            .alarm_en_in   (alarm_en_in[i]),
            .alarm_val_in  (alarm_in[i*WIDTH +: WIDTH]),
            .counter_in    (counter_q),
            .tick_upd_in   (upd_q),
            .captured_out  (captured_out[i*WIDTH +: WIDTH]),
            .valid_out     (capture_valid_out[i]),
            .ovr_out       (capture_ovr_out[i]),
            .alarm_out     (alarm_out[i])
        );
    end

endmodule

// File: tb/tb_multi_channel_timer.sv
// tb/tb_multi_channel_timer.sv - self-checking bench for multi_channel_timer
module tb_multi_channel_timer;

    localparam int W  = 8;
    localparam int NC = 4;
    localparam int PW = 3;
    localparam int M_IDLE = 0, M_RUN = 1, M_DONE = 2;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            start = 0, stop = 0, clr = 0, oneshot = 0;
    logic [PW-1:0]   ps = '0;
    logic [W-1:0]    rl = '0;
    logic [NC-1:0]   cap = '0, rcap = '0, aen = '0;
    logic [NC*W-1:0] alm = '0;
    logic [W-1:0]    counter_out;
    logic [NC*W-1:0] captured_out;
    logic [NC-1:0]   valid_out, ovr_out, alarm_out;
    logic            wrap_out, running_out;

    int n_cmp = 0;
    int n_err = 0;

    multi_channel_timer #(.WIDTH(W), .N_CH(NC), .PRE_W(PW)) dut (
        .clk_in(clk), .rst_in(rst), .start_in(start), .stop_in(stop), .clear_in(clr),
        .oneshot_in(oneshot), .prescale_in(ps), .reload_in(rl), .capture_in(cap),
        .rst_capture_in(rcap), .alarm_en_in(aen), .alarm_in(alm),
        .counter_out(counter_out), .captured_out(captured_out),
        .capture_valid_out(valid_out), .capture_ovr_out(ovr_out),
        .alarm_out(alarm_out), .wrap_out(wrap_out), .running_out(running_out)
    );

    always #5 clk = ~clk;

    // Reference model: timer behaviour expressed as plain integer arithmetic.
    int          m_state, m_cnt, m_pre;
    bit          m_armed, m_wrap, m_upd;
    bit          h_s, h_p, h_c;
    bit [NC-1:0] h_cap, h_rc, m_valid, m_ovr, m_alarm;
    int          m_capv[NC];

    task automatic model_reset();
        m_state = M_IDLE; m_cnt = 0; m_pre = 0; m_armed = 0; m_wrap = 0; m_upd = 0;
        h_s = 0; h_p = 0; h_c = 0; h_cap = '0; h_rc = '0;
        m_valid = '0; m_ovr = '0; m_alarm = '0;
        for (int i = 0; i < NC; i++) m_capv[i] = 0;
    endtask

    task automatic model_step();
        bit sev, pev, cev, tk, adv, nw, nu;
        bit [NC-1:0] cv, rv;
        int ns, nc, np;
        sev = m_armed && start && !h_s;
        pev = m_armed && stop && !h_p;
        cev = m_armed && clr && !h_c;
        cv  = m_armed ? (cap & ~h_cap) : '0;
        rv  = m_armed ? (rcap & ~h_rc) : '0;
        for (int i = 0; i < NC; i++) begin
            m_alarm[i] = m_upd && aen[i] && (m_cnt == int'(alm[i*W +: W]));
            if (cv[i]) begin
                m_ovr[i]   = rv[i] ? 1'b0 : (m_ovr[i] | m_valid[i]);
                m_valid[i] = 1'b1;
                m_capv[i]  = m_cnt;
            end else if (rv[i]) begin
                m_valid[i] = 1'b0;
                m_ovr[i]   = 1'b0;
            end
        end
        ns = m_state; nc = m_cnt; np = m_pre; nw = 0; nu = 0;
        tk  = (m_state == M_RUN) && (m_pre == int'(ps));
        adv = tk && !cev;
        if (m_state == M_RUN) np = tk ? 0 : (m_pre + 1) % (1 << PW);
        if (adv) begin
            if (m_cnt == int'(rl)) begin
                nw = 1;
                if (oneshot) ns = M_DONE;
                else begin nc = 0; nu = 1; end
            end else begin
                nc = (m_cnt + 1) % (1 << W);
                nu = 1;
            end
        end
        if (sev && !pev && m_state != M_RUN) begin
            if (m_state == M_DONE) begin nc = 0; np = 0; end
            ns = M_RUN;
        end
        if (pev && m_state == M_RUN) ns = M_IDLE;
        if (cev) begin nc = 0; np = 0; end
        m_state = ns; m_cnt = nc; m_pre = np; m_wrap = nw; m_upd = nu; m_armed = 1;
        h_s = start; h_p = stop; h_c = clr; h_cap = cap; h_rc = rcap;
    endtask

    task automatic step();
        @(posedge clk);
        if (rst) model_reset(); else model_step();
        #1;
    endtask

    task automatic quiet_inputs();
        start = 0; stop = 0; clr = 0; cap = '0; rcap = '0;
    endtask

    task automatic do_reset();
        quiet_inputs();
        rst = 1; model_reset();
        step(); step();
        rst = 0;
        step(); step();
    endtask

    task automatic pulse_start();
        start = 1; step(); start = 0;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++; if (counter_out !== '0) begin n_err++; $display("FAIL reset_counter got %0d exp 0", counter_out); end
        n_cmp++; if (running_out !== 1'b0) begin n_err++; $display("FAIL reset_running got %b exp 0", running_out); end
        n_cmp++; if ({valid_out, ovr_out, alarm_out, wrap_out} !== '0) begin n_err++; $display("FAIL reset_flags got %h exp 0", {valid_out, ovr_out, alarm_out, wrap_out}); end
        n_cmp++; if (captured_out !== '0) begin n_err++; $display("FAIL reset_captured got %h exp 0", captured_out); end
    endtask

    task automatic test_periodic();
        do_reset();
        ps = 3; rl = 9; oneshot = 0;
        pulse_start();
        for (int k = 1; k <= 100; k++) begin
            step();
            n_cmp++; if (counter_out !== W'((k / 4) % 10)) begin n_err++; $display("FAIL periodic_cnt k=%0d got %0d exp %0d", k, counter_out, (k / 4) % 10); end
            n_cmp++; if (wrap_out !== (k % 40 == 0)) begin n_err++; $display("FAIL periodic_wrap k=%0d got %b exp %b", k, wrap_out, k % 40 == 0); end
        end
    endtask

    task automatic test_oneshot();
        do_reset();
        ps = 0; rl = 5; oneshot = 1;
        pulse_start();
        for (int k = 1; k <= 10; k++) begin
            step();
            n_cmp++; if (counter_out !== W'((k < 5) ? k : 5)) begin n_err++; $display("FAIL oneshot_cnt k=%0d got %0d exp %0d", k, counter_out, (k < 5) ? k : 5); end
            n_cmp++; if (running_out !== (k <= 5)) begin n_err++; $display("FAIL oneshot_run k=%0d got %b exp %b", k, running_out, k <= 5); end
        end
        pulse_start();
        n_cmp++; if (counter_out !== '0 || running_out !== 1'b1) begin n_err++; $display("FAIL oneshot_restart got cnt=%0d run=%b exp cnt=0 run=1", counter_out, running_out); end
        step();
        n_cmp++; if (counter_out !== W'(1)) begin n_err++; $display("FAIL oneshot_restart_inc got %0d exp 1", counter_out); end
    endtask

    task automatic test_capture();
        do_reset();
        ps = 0; rl = 200; oneshot = 0;
        pulse_start();
        for (int k = 1; k <= 7; k++) step();
        cap[2] = 1; step(); cap[2] = 0;
        n_cmp++; if (captured_out[2*W +: W] !== W'(7) || valid_out !== 4'b0100 || ovr_out !== 4'b0000) begin n_err++; $display("FAIL capture_first got v=%0d valid=%b ovr=%b exp v=7 valid=0100 ovr=0000", captured_out[2*W +: W], valid_out, ovr_out); end
        for (int k = 9; k <= 12; k++) step();
        cap[2] = 1; step(); cap[2] = 0;
        n_cmp++; if (captured_out[2*W +: W] !== W'(12) || valid_out[2] !== 1'b1 || ovr_out[2] !== 1'b1) begin n_err++; $display("FAIL capture_overrun got v=%0d valid=%b ovr=%b exp v=12 valid=1 ovr=1", captured_out[2*W +: W], valid_out[2], ovr_out[2]); end
        rcap[2] = 1; step(); rcap[2] = 0;
        n_cmp++; if (valid_out[2] !== 1'b0 || ovr_out[2] !== 1'b0) begin n_err++; $display("FAIL capture_clear got valid=%b ovr=%b exp 0 0", valid_out[2], ovr_out[2]); end
        cap[2] = 1; step(); cap[2] = 0; step();
        cap[2] = 1; rcap[2] = 1; step(); cap[2] = 0; rcap[2] = 0;
        n_cmp++; if (valid_out[2] !== 1'b1 || ovr_out[2] !== 1'b0) begin n_err++; $display("FAIL capture_vs_clear got valid=%b ovr=%b exp 1 0", valid_out[2], ovr_out[2]); end
    endtask

    task automatic test_alarm();
        do_reset();
        ps = 0; rl = 200; oneshot = 0;
        alm = '0; alm[0 +: W] = 100; alm[W +: W] = 100; aen = 4'b0001;
        pulse_start();
        for (int k = 1; k <= 110; k++) begin
            step();
            n_cmp++; if (alarm_out[0] !== (k == 101)) begin n_err++; $display("FAIL alarm0 k=%0d got %b exp %b", k, alarm_out[0], k == 101); end
            n_cmp++; if (alarm_out[1] !== 1'b0) begin n_err++; $display("FAIL alarm1 k=%0d got %b exp 0", k, alarm_out[1]); end
        end
        aen = '0; alm = '0;
    endtask

    task automatic test_start_stop_clear();
        do_reset();
        ps = 3; rl = 200; oneshot = 0;
        start = 1; stop = 1; step(); start = 0; stop = 0;
        n_cmp++; if (running_out !== 1'b0) begin n_err++; $display("FAIL start_stop_same got %b exp 0", running_out); end
        step();
        n_cmp++; if (running_out !== 1'b0) begin n_err++; $display("FAIL start_stop_hold got %b exp 0", running_out); end
        pulse_start();
        for (int k = 1; k <= 83; k++) step();
        n_cmp++; if (counter_out !== W'(20)) begin n_err++; $display("FAIL clear_pre_cnt got %0d exp 20", counter_out); end
        clr = 1; step(); clr = 0;
        n_cmp++; if (counter_out !== '0 || running_out !== 1'b1) begin n_err++; $display("FAIL clear_tick got cnt=%0d run=%b exp cnt=0 run=1", counter_out, running_out); end
        for (int k = 0; k < 4; k++) step();
        n_cmp++; if (counter_out !== W'(1)) begin n_err++; $display("FAIL clear_resume got %0d exp 1", counter_out); end
        stop = 1; step(); stop = 0;
        for (int k = 0; k < 5; k++) step();
        n_cmp++; if (running_out !== 1'b0 || counter_out !== W'(1)) begin n_err++; $display("FAIL stop_hold got cnt=%0d run=%b exp cnt=1 run=0", counter_out, running_out); end
    endtask

    task automatic test_reset_midrun();
        do_reset();
        ps = 0; rl = 200; oneshot = 0;
        pulse_start();
        for (int k = 1; k <= 49; k++) step();
        cap[0] = 1; step(); cap[0] = 0;
        n_cmp++; if (counter_out !== W'(50) || valid_out[0] !== 1'b1) begin n_err++; $display("FAIL midrun_pre got cnt=%0d valid=%b exp cnt=50 valid=1", counter_out, valid_out[0]); end
        #2; rst = 1; model_reset(); #1;
        n_cmp++; if (counter_out !== '0 || running_out !== 1'b0 || captured_out !== '0) begin n_err++; $display("FAIL midrun_async got cnt=%0d run=%b cap=%h exp all 0", counter_out, running_out, captured_out); end
        n_cmp++; if ({valid_out, ovr_out, alarm_out, wrap_out} !== '0) begin n_err++; $display("FAIL midrun_flags got %h exp 0", {valid_out, ovr_out, alarm_out, wrap_out}); end
        start = 1;
        step(); step();
        rst = 0;
        for (int k = 0; k < 3; k++) step();
        n_cmp++; if (running_out !== 1'b0) begin n_err++; $display("FAIL midrun_held_start got %b exp 0", running_out); end
        start = 0; step();
        pulse_start();
        n_cmp++; if (running_out !== 1'b1 || counter_out !== '0) begin n_err++; $display("FAIL midrun_new_start got run=%b cnt=%0d exp run=1 cnt=0", running_out, counter_out); end
    endtask

    task automatic test_boundaries();
        do_reset();
        ps = 0; rl = 255; oneshot = 0;
        pulse_start();
        for (int k = 1; k <= 255; k++) step();
        n_cmp++; if (counter_out !== W'(255) || wrap_out !== 1'b0) begin n_err++; $display("FAIL max_reload_top got cnt=%0d wrap=%b exp 255 0", counter_out, wrap_out); end
        step();
        n_cmp++; if (counter_out !== '0 || wrap_out !== 1'b1) begin n_err++; $display("FAIL max_reload_wrap got cnt=%0d wrap=%b exp 0 1", counter_out, wrap_out); end
        do_reset();
        rl = 0;
        pulse_start();
        for (int k = 1; k <= 5; k++) begin
            step();
            n_cmp++; if (counter_out !== '0 || wrap_out !== 1'b1) begin n_err++; $display("FAIL zero_reload k=%0d got cnt=%0d wrap=%b exp 0 1", k, counter_out, wrap_out); end
        end
    endtask

    task automatic test_random();
        logic [NC*W-1:0] exp_cap;
        for (int seg = 0; seg < 6; seg++) begin
            do_reset();
            rl = W'($urandom_range(0, 15));
            ps = PW'($urandom_range(0, 3));
            oneshot = 1'($urandom_range(0, 1));
            aen = NC'($urandom);
            for (int i = 0; i < NC; i++) alm[i*W +: W] = W'($urandom_range(0, 15));
            for (int c = 0; c < 250; c++) begin
                start = ($urandom_range(0, 7) == 0);
                stop  = ($urandom_range(0, 23) == 0);
                clr   = ($urandom_range(0, 39) == 0);
                for (int i = 0; i < NC; i++) begin
                    cap[i]  = ($urandom_range(0, 7) == 0);
                    rcap[i] = ($urandom_range(0, 15) == 0);
                end
                step();
                for (int i = 0; i < NC; i++) exp_cap[i*W +: W] = W'(m_capv[i]);
                n_cmp++; if (counter_out !== W'(m_cnt)) begin n_err++; $display("FAIL rand_cnt seg=%0d c=%0d got %0d exp %0d", seg, c, counter_out, m_cnt); end
                n_cmp++; if (running_out !== (m_state == M_RUN) || wrap_out !== m_wrap) begin n_err++; $display("FAIL rand_run_wrap seg=%0d c=%0d got %b%b exp %b%b", seg, c, running_out, wrap_out, m_state == M_RUN, m_wrap); end
                n_cmp++; if (alarm_out !== m_alarm) begin n_err++; $display("FAIL rand_alarm seg=%0d c=%0d got %b exp %b", seg, c, alarm_out, m_alarm); end
                n_cmp++; if (valid_out !== m_valid || ovr_out !== m_ovr) begin n_err++; $display("FAIL rand_flags seg=%0d c=%0d got %b/%b exp %b/%b", seg, c, valid_out, ovr_out, m_valid, m_ovr); end
                n_cmp++; if (captured_out !== exp_cap) begin n_err++; $display("FAIL rand_captured seg=%0d c=%0d got %h exp %h", seg, c, captured_out, exp_cap); end
            end
        end
        quiet_inputs();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        test_reset();
        test_periodic();
        test_oneshot();
        test_capture();
        test_alarm();
        test_start_stop_clear();
        test_reset_midrun();
        test_boundaries();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
